// File: rtl/sram_1r1w_arb.sv
// sram_1r1w_arb: a 1-read/1-write memory built on one single-port la_spram.
// Writes go into a small in-order buffer. A fixed-priority arbiter shares the
// single SRAM port between buffer drains and reads. A read whose address matches
// a buffered write waits until every matching entry has drained.
// Optional build macro: SRAM_1R1W_OREG_EN registers the SRAM output, so read
// latency becomes 2 cycles with full throughput.

module la_spram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          ce,
  input  logic          we,
  input  logic [DW-1:0] wmask,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [2**AW];

  // single port: bit-masked write or registered read, one per enabled cycle
  always_ff @(posedge clk) begin
    if (ce && we) mem[addr] <= (mem[addr] & ~wmask) | (din & wmask);
    if (ce && !we) dout <= mem[addr];
  end

endmodule

module sram_1r1w_arb #(
  parameter int DW   = 32,
  parameter int AW   = 10,
  parameter int WBUF = 4
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [AW-1:0]   w_addr,
  input  logic [DW-1:0]   w_data,
  input  logic [DW/8-1:0] w_mask,
  input  logic            r_valid,
  output logic            r_ready,
  input  logic [AW-1:0]   r_addr,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data
);

  localparam int CW = $clog2(WBUF + 1);
  localparam int PW = (WBUF > 1) ? $clog2(WBUF) : 1;
  localparam int MW = DW / 8;

  logic [AW-1:0]   buf_addr [WBUF];
  logic [DW-1:0]   buf_data [WBUF];
  logic [MW-1:0]   buf_mask [WBUF];
  logic [WBUF-1:0] buf_vld;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            buf_full;
  logic            hazard;
  logic            rd_grant;
  logic            wr_drain;
  logic            w_fire;
  logic            rd_pend;

  logic            sram_ce;
  logic            sram_we;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_wmask;
  logic [DW-1:0]   sram_dout;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(WBUF - 1)) ? '0 : p + 1'b1;
  endfunction

  assign buf_full = (count == CW'(WBUF));
  assign w_ready  = !buf_full;
  assign w_fire   = w_valid && w_ready;
  assign r_ready  = rd_grant;

  // flag a read that would bypass a buffered write to the same address
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WBUF; i++) begin
      if (buf_vld[i] && (buf_addr[i] == r_addr)) hazard = 1'b1;
    end
  end

  // one SRAM op per cycle: full-buffer drain, then read, then opportunistic drain
  always_comb begin
    rd_grant = nreset && !buf_full && r_valid && !hazard;
    wr_drain = nreset && (count != '0) && !rd_grant;
  end

  // steer the single SRAM port to the granted operation and expand byte enables
  always_comb begin
    sram_ce    = rd_grant || wr_drain;
    sram_we    = wr_drain;
    sram_addr  = rd_grant ? r_addr : buf_addr[rd_ptr];
    sram_wmask = '0;
    for (int b = 0; b < MW; b++) begin
      sram_wmask[8*b +: 8] = {8{buf_mask[rd_ptr][b]}};
    end
  end

  // buffer payload storage; contents are only meaningful where buf_vld is set
  always_ff @(posedge clk) begin
    if (w_fire) begin
      buf_addr[wr_ptr] <= w_addr;
      buf_data[wr_ptr] <= w_data;
      buf_mask[wr_ptr] <= w_mask;
    end
  end

  // buffer bookkeeping; reset discards every buffered write
  always_ff @(posedge clk) begin
    if (!nreset) begin
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      buf_vld <= '0;
    end else begin
      if (w_fire) wr_ptr <= ptr_next(wr_ptr);
      if (wr_drain) rd_ptr <= ptr_next(rd_ptr);
      if (wr_drain) buf_vld[rd_ptr] <= 1'b0;
      if (w_fire) buf_vld[wr_ptr] <= 1'b1;
      if (w_fire && !wr_drain) count <= count + 1'b1;
      else if (!w_fire && wr_drain) count <= count - 1'b1;
    end
  end

  la_spram #(
    .DW(DW),
    .AW(AW)
  ) u_spram (
    .clk  (clk),
    .ce   (sram_ce),
    .we   (sram_we),
    .wmask(sram_wmask),
    .addr (sram_addr),
    .din  (buf_data[rd_ptr]),
    .dout (sram_dout)
  );

  // track which cycle holds a fresh read result; reset drops it
  always_ff @(posedge clk) begin
    if (!nreset) rd_pend <= 1'b0;
    else         rd_pend <= rd_grant;
  end

`ifdef SRAM_1R1W_OREG_EN
  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;

  // extra output stage after the SRAM, zero when no result is present
  always_ff @(posedge clk) begin
    if (!nreset) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_pend;
      rd_data_q  <= rd_pend ? sram_dout : '0;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`else
  assign rd_valid = rd_pend;
  assign rd_data  = rd_pend ? sram_dout : '0;
`endif

endmodule

// File: tb/tb_sram_1r1w_arb.sv
// tb_sram_1r1w_arb: randomized and directed bench for sram_1r1w_arb.
// The reference model is a word array plus the list of writes accepted but
// possibly not yet in the SRAM; a read expects the array with those applied.
// Build macro SRAM_1R1W_OREG_EN selects the 2-cycle read latency expectation.

module tb_sram_1r1w_arb;

  localparam int DW   = 32;
  localparam int AW   = 10;
  localparam int WBUF = 4;
  localparam int MW   = DW / 8;
`ifdef SRAM_1R1W_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          nreset;
  logic          w_valid;
  logic          w_ready;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [MW-1:0] w_mask;
  logic          r_valid;
  logic          r_ready;
  logic [AW-1:0] r_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;

  sram_1r1w_arb #(
    .DW(DW),
    .AW(AW),
    .WBUF(WBUF)
  ) dut (
    .clk     (clk),
    .nreset  (nreset),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .w_mask  (w_mask),
    .r_valid (r_valid),
    .r_ready (r_ready),
    .r_addr  (r_addr),
    .rd_valid(rd_valid),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
  } wr_t;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rsp_t;

  logic [DW-1:0] mem_model [64];
  wr_t           pend_q [$];
  rsp_t          exp_q [$];
  int            check_count = 0;
  int            error_count = 0;
  int            cyc = 0;
  logic          w_fire;
  logic          r_fire;
  logic          w_ready_s;
  logic          r_ready_s;
  logic [DW-1:0] last_rd;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                               input logic [MW-1:0] m);
    logic [DW-1:0] v;
    v = old;
    for (int b = 0; b < MW; b++) begin
      if (m[b]) v[8*b +: 8] = d[8*b +: 8];
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] readModel(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = mem_model[a[5:0]];
    foreach (pend_q[i]) begin
      if (pend_q[i].addr == a) v = mergeBytes(v, pend_q[i].data, pend_q[i].mask);
    end
    return v;
  endfunction

  task automatic commitOldest();
    wr_t w;
    w = pend_q.pop_front();
    mem_model[w.addr[5:0]] = mergeBytes(mem_model[w.addr[5:0]], w.data, w.mask);
  endtask

  // sample just before the rising edge: check the response, then update the model
  task automatic modelStep();
    rsp_t r;
    wr_t  w;
    w_ready_s = w_ready;
    r_ready_s = r_ready;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      checkOutput("rd_valid", rd_valid, 1'b1);
      checkOutput("rd_data", rd_data, r.data);
      last_rd = rd_data;
    end else begin
      checkOutput("rd_valid_idle", rd_valid, 1'b0);
      checkOutput("rd_data_idle", rd_data, '0);
    end
    w_fire = w_valid && w_ready;
    r_fire = r_valid && r_ready;
    if (!nreset) begin
      exp_q.delete();
      pend_q.delete();
      w_fire = 1'b0;
      r_fire = 1'b0;
    end else begin
      if (r_fire) begin
        r.data = readModel(r_addr);
        r.due  = cyc + LAT;
        exp_q.push_back(r);
      end
      if (w_fire) begin
        w.addr = w_addr;
        w.data = w_data;
        w.mask = w_mask;
        pend_q.push_back(w);
        if (pend_q.size() > WBUF) commitOldest();
      end
    end
    cyc++;
  endtask

  task automatic applyStimulus(input logic rst_n, input logic wv, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic [MW-1:0] wm,
                               input logic rv, input logic [AW-1:0] ra);
    @(negedge clk);
    nreset  = rst_n;
    w_valid = wv;
    w_addr  = wa;
    w_data  = wd;
    w_mask  = wm;
    r_valid = rv;
    r_addr  = ra;
    #4;
    modelStep();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // with no reads, every buffered write drains within WBUF cycles
  task automatic settle();
    idle(WBUF + 2);
    while (pend_q.size() > 0) commitOldest();
  endtask

  task automatic doWrite(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b1, a, d, m, 1'b0, '0);
      n++;
    end while (!w_fire && n < 20);
    checkOutput("write_accept", w_fire, 1'b1);
  endtask

  task automatic doRead(input logic [AW-1:0] a);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, a);
      n++;
    end while (!r_fire && n < 40);
    checkOutput("read_grant", r_fire, 1'b1);
    idle(LAT + 1);
  endtask

  task automatic fullTest();
    int            n;
    logic [DW-1:0] d;
    settle();
    for (int i = 0; i <= WBUF; i++) begin
      n = 0;
      d = $urandom;
      do begin
        applyStimulus(1'b1, 1'b1, AW'(40 + i), d, '1, 1'b1, '0);
        if (i == WBUF && n == 0) begin
          checkOutput("full_w_ready", w_ready_s, 1'b0);
          checkOutput("full_r_ready", r_ready_s, 1'b0);
        end
        n++;
      end while (!w_fire && n < 10);
      checkOutput("full_w_accept", w_fire, 1'b1);
      checkOutput("full_rd_grant", r_fire, 1'b1);
    end
    settle();
    for (int i = 0; i <= WBUF; i++) doRead(AW'(40 + i));
  endtask

  task automatic resetTest();
    logic [DW-1:0] pre [3];
    settle();
    for (int j = 0; j < 3; j++) pre[j] = mem_model[20 + j];
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b1, 1'b1, AW'(20 + j), ~pre[j], '1, 1'b1, AW'(1));
      checkOutput("rst_w_accept", w_fire, 1'b1);
      checkOutput("rst_r_grant", r_fire, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    checkOutput("rst_w_ready", w_ready_s, 1'b1);
    checkOutput("rst_r_ready", r_ready_s, 1'b0);
    checkOutput("rst_rd_valid", rd_valid, 1'b0);
    settle();
    for (int j = 0; j < 3; j++) begin
      doRead(AW'(20 + j));
      checkOutput("rst_discard", last_rd, pre[j]);
    end
  endtask

  task automatic randomTest(input int cycles);
    logic          rv_hold;
    logic [AW-1:0] ra_hold;
    int            n;
    rv_hold = 1'b0;
    ra_hold = '0;
    for (int c = 0; c < cycles; c++) begin
      if (!rv_hold) begin
        rv_hold = ($urandom_range(0, 1) == 1);
        ra_hold = AW'($urandom_range(0, 31));
      end
      applyStimulus(1'b1, ($urandom_range(0, 2) != 0), AW'($urandom_range(0, 31)), $urandom,
                    MW'($urandom_range(0, 15)), rv_hold, ra_hold);
      if (r_fire) rv_hold = 1'b0;
    end
    n = 0;
    while (rv_hold && n < 50) begin
      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, ra_hold);
      if (r_fire) rv_hold = 1'b0;
      n++;
    end
    checkOutput("rnd_final_grant", rv_hold, 1'b0);
    settle();
    for (int a = 0; a < 32; a++) doRead(AW'(a));
  endtask

  initial begin
    nreset  = 1'b0;
    w_valid = 1'b0;
    w_addr  = '0;
    w_data  = '0;
    w_mask  = '0;
    r_valid = 1'b0;
    r_addr  = '0;
    last_rd = '0;

    $display("[TB] reset and idle");
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
    checkOutput("reset_w_ready", w_ready_s, 1'b1);
    checkOutput("reset_r_ready", r_ready_s, 1'b0);
    checkOutput("reset_rd_valid", rd_valid, 1'b0);
    checkOutput("reset_rd_data", rd_data, '0);

    $display("[TB] preload addresses 0..31");
    for (int a = 0; a < 32; a++) doWrite(AW'(a), $urandom, '1);
    settle();

    $display("[TB] basic write/read");
    doWrite(AW'(5), 32'hDEADBEEF, 4'hF);
    doRead(AW'(5));
    checkOutput("basic_read", last_rd, 32'hDEADBEEF);

    $display("[TB] byte mask merge");
    doWrite(AW'(5), 32'hFFFFFFFF, 4'hF);
    doWrite(AW'(5), 32'h00001200, 4'b0010);
    doRead(AW'(5));
    checkOutput("mask_merge", last_rd, 32'hFFFF12FF);

    $display("[TB] read-after-write hazard");
    settle();
    applyStimulus(1'b1, 1'b1, AW'(9), 32'hCAFE0009, 4'hF, 1'b0, '0);
    checkOutput("haz_w_accept", w_fire, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, AW'(9));
    checkOutput("haz_r_stall", r_ready_s, 1'b0);
    doRead(AW'(9));
    checkOutput("haz_new_data", last_rd, 32'hCAFE0009);

    $display("[TB] full buffer with continuous reads");
    fullTest();

    $display("[TB] reset with buffered writes");
    resetTest();

    $display("[TB] randomized traffic");
    randomTest(400);

    idle(LAT + 2);
    checkOutput("rsp_drained", 64'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
